// File: rtl/dmem_arbiter_pkg.sv
//==============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared widths, port indices and response-tag type for the DMEM
//            arbiter and its round-robin core.
// Revision : 1.0
//==============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Outstanding read: which port gets next cycle's mem_rdata.
    typedef struct packed {
        logic valid;
        logic port;
    } rsp_tag_t;

endpackage : dmem_arbiter_pkg

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
//==============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin grant, purely combinational; on a tie
//            the requester that was not granted last wins.
// Revision : 1.0
//==============================================================================
`default_nettype none

module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    logic w_tie;

    assign w_tie = req[PORT_CPU] & req[PORT_DBG];

    always_comb begin
        gnt = 2'b00;
        if (w_tie) begin
            if (last == PORT_DBG) begin
                gnt[PORT_CPU] = 1'b1;
            end else begin
                gnt[PORT_DBG] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port DMEM between the CPU LSU (port 0) and the
//            debug/loader master (port 1); routes read data back by tag.
// Revision : 1.0
//==============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                  sysclk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [BE_W-1:0]       m0_be,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [BE_W-1:0]       m1_be,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [BE_W-1:0]       mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [1:0]           w_req;
    logic [1:0]           w_gnt;
    logic                 w_xfer;
    logic                 w_conflict;
    logic                 w_rsp_live;

    logic                 r_last;
    rsp_tag_t             r_tag;
    logic [CNT_WIDTH-1:0] r_conflict_cnt;

    // Masking requests keeps every grant, and so every transfer, off during reset.
    assign w_req[PORT_CPU] = m0_req & ~rst;
    assign w_req[PORT_DBG] = m1_req & ~rst;

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign m0_gnt     = w_gnt[PORT_CPU];
    assign m1_gnt     = w_gnt[PORT_DBG];
    assign w_xfer     = |w_gnt;
    assign w_conflict = m0_req & m1_req;

    always_comb begin
        mem_en    = w_xfer;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[PORT_CPU]) begin
            mem_we    = m0_we;
            mem_be    = m0_be;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (w_gnt[PORT_DBG]) begin
            mem_we    = m1_we;
            mem_be    = m1_be;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_last         <= PORT_DBG;
            r_tag          <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_last <= w_gnt[PORT_DBG];
            end
            r_tag.valid <= w_xfer & ~mem_we;
            r_tag.port  <= w_gnt[PORT_DBG];
            if (w_conflict && (r_conflict_cnt != c_cnt_max)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // A reset arriving while a read response is due drops that response.
    assign w_rsp_live = r_tag.valid & ~rst;

    assign m0_rvalid    = w_rsp_live & (r_tag.port == PORT_CPU);
    assign m1_rvalid    = w_rsp_live & (r_tag.port == PORT_DBG);
    assign m0_rdata     = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata     = m1_rvalid ? mem_rdata : '0;
    assign conflict_cnt = r_conflict_cnt;

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a reference model of the
//            arbitration rules and an independent memory image.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BEW = DW / 8;
    localparam int CW  = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic           sysclk = 1'b0;
    logic           rst;
    logic           m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [BEW-1:0] m0_be;
    logic [AW-1:0]  m0_addr;
    logic [DW-1:0]  m0_wdata, m0_rdata;
    logic           m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [BEW-1:0] m1_be;
    logic [AW-1:0]  m1_addr;
    logic [DW-1:0]  m1_wdata, m1_rdata;
    logic           mem_en, mem_we;
    logic [BEW-1:0] mem_be;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata = '0;
    logic [CW-1:0]  conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sysclk = ~sysclk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .sysclk(sysclk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEAD_BEEF;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old,
                                               input logic [DW-1:0] wd,
                                               input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BEW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Synchronous memory driven purely by the DUT's memory port.
    logic [DW-1:0] tb_mem [logic [AW-1:0]];
    always @(posedge sysclk) begin
        if (mem_en) begin
            if (mem_we) begin
                tb_mem[mem_addr] = merge_be(tb_mem.exists(mem_addr) ? tb_mem[mem_addr]
                                            : init_word(mem_addr), mem_wdata, mem_be);
            end else begin
                mem_rdata <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : init_word(mem_addr);
            end
        end
    end

    // Reference model state, updated from the masters' inputs only.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          ref_last   = 1'b1;
    logic          pend_valid = 1'b0;
    logic          pend_port  = 1'b0;
    logic [DW-1:0] pend_data  = '0;
    logic [CW-1:0] ref_cnt    = '0;

    logic           eg0, eg1, exp_en, exp_we, exp_rv0, exp_rv1;
    logic [BEW-1:0] exp_be;
    logic [AW-1:0]  exp_addr;
    logic [DW-1:0]  exp_wdata, exp_rd0, exp_rd1;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic predict();
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                eg0 = ref_last;      // the port that did not win last time
                eg1 = !ref_last;
            end else begin
                eg0 = m0_req;
                eg1 = m1_req;
            end
        end
        exp_en = eg0 | eg1;
        {exp_we, exp_be, exp_addr, exp_wdata} = '0;
        if (eg0) {exp_we, exp_be, exp_addr, exp_wdata} = {m0_we, m0_be, m0_addr, m0_wdata};
        if (eg1) {exp_we, exp_be, exp_addr, exp_wdata} = {m1_we, m1_be, m1_addr, m1_wdata};
        exp_rv0 = pend_valid && !pend_port && !rst;
        exp_rv1 = pend_valid && pend_port && !rst;
        exp_rd0 = exp_rv0 ? pend_data : '0;
        exp_rd1 = exp_rv1 ? pend_data : '0;
    endtask

    task automatic commit();
        if (rst) begin
            ref_last   = 1'b1;
            pend_valid = 1'b0;
            ref_cnt    = '0;
        end else begin
            if (m0_req && m1_req && ref_cnt != CNT_MAX) ref_cnt = ref_cnt + CW'(1);
            pend_valid = 1'b0;
            if (exp_en) begin
                ref_last = eg1;
                if (exp_we) begin
                    ref_mem[exp_addr] = merge_be(ref_rd(exp_addr), exp_wdata, exp_be);
                end else begin
                    pend_valid = 1'b1;
                    pend_port  = eg1;
                    pend_data  = ref_rd(exp_addr);
                end
            end
        end
    endtask

    task automatic tick();
        commit();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic set_m0(input logic rq, input logic we, input logic [BEW-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
        m0_req = rq; m0_we = we; m0_be = be; m0_addr = a; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic rq, input logic we, input logic [BEW-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
        m1_req = rq; m1_we = we; m1_be = be; m1_addr = a; m1_wdata = wd;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1; predict(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_m0(1'b1, 1'b0, 4'hF, 12'h020, '0);
        set_m1(1'b1, 1'b1, 4'hF, 12'h021, 32'hCAFE_F00D);
        @(negedge sysclk);
        for (int i = 0; i < 3; i++) begin
            #1; predict();
            n_checks++;
            if ({m0_gnt, m1_gnt, mem_en} !== {eg0, eg1, exp_en}) begin
                n_errors++;
                $display("FAIL reset_gnt cyc%0d: got gnt0/gnt1/en=%b%b%b expected %b%b%b",
                         i, m0_gnt, m1_gnt, mem_en, eg0, eg1, exp_en);
            end
            n_checks++;
            if ({mem_we, mem_be, mem_addr, mem_wdata, m0_rvalid, m1_rvalid, m0_rdata} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs cyc%0d: got addr=%h rv0=%b rv1=%b rdata0=%h expected all zero",
                         i, mem_addr, m0_rvalid, m1_rvalid, m0_rdata);
            end
            n_checks++;
            if (conflict_cnt !== ref_cnt) begin
                n_errors++;
                $display("FAIL reset_cnt cyc%0d: got %0d expected %0d", i, conflict_cnt, ref_cnt);
            end
            tick();
        end
        rst = 1'b0;
        #1; predict();
        n_checks++;
        if ({m0_gnt, m1_gnt} !== {eg0, eg1} || m0_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_first_tie: got gnt0/gnt1=%b%b expected 10", m0_gnt, m1_gnt);
        end
        tick();
    endtask

    task automatic test_single_read();
        idle();
        #1; predict(); tick();
        set_m0(1'b1, 1'b0, 4'hF, 12'h010, '0);
        #1; predict();
        n_checks++;
        if ({m0_gnt, mem_en, mem_we, mem_addr} !== {eg0, exp_en, exp_we, exp_addr}) begin
            n_errors++;
            $display("FAIL single_read_gnt: got gnt0=%b en=%b we=%b addr=%h expected %b %b %b %h",
                     m0_gnt, mem_en, mem_we, mem_addr, eg0, exp_en, exp_we, exp_addr);
        end
        tick();
        idle();
        #1; predict();
        n_checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_read_rsp: got rv0=%b rdata0=%h rv1=%b expected 1 deadbeef 0",
                     m0_rvalid, m0_rdata, m1_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        do_reset();
        set_m0(1'b1, 1'b0, 4'hF, 12'($urandom_range(63)), '0);
        set_m1(1'b1, 1'b1, 4'hF, 12'($urandom_range(63)), 32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            #1; predict();
            n_checks++;
            if ({m0_gnt, m1_gnt} !== {eg0, eg1} || m0_gnt !== ((i % 2) == 0)) begin
                n_errors++;
                $display("FAIL contention_gnt cyc%0d: got gnt0/gnt1=%b%b expected %b%b",
                         i, m0_gnt, m1_gnt, eg0, eg1);
            end
            n_checks++;
            if ({m0_rvalid, m0_rdata, m1_rvalid} !== {exp_rv0, exp_rd0, exp_rv1}) begin
                n_errors++;
                $display("FAIL contention_rsp cyc%0d: got rv0=%b rdata0=%h rv1=%b expected %b %h %b",
                         i, m0_rvalid, m0_rdata, m1_rvalid, exp_rv0, exp_rd0, exp_rv1);
            end
            tick();
            if (eg0) m0_addr = 12'($urandom_range(63));
            if (eg1) m1_addr = 12'($urandom_range(63));
        end
        idle();
        #1; predict();
        n_checks++;
        if (conflict_cnt !== 4'd6 || m1_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL contention_cnt: got cnt=%0d rv1=%b expected 6 0", conflict_cnt, m1_rvalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        #1; predict(); tick();
        set_m1(1'b1, 1'b0, 4'hF, 12'h001, '0);
        #1; predict(); tick();
        set_m1(1'b1, 1'b0, 4'hF, 12'h002, '0);
        for (int i = 0; i < 2; i++) begin
            #1; predict();
            n_checks++;
            if (m1_rvalid !== 1'b1 || m1_rdata !== exp_rd1 || m0_rvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b_rsp%0d: got rv1=%b rdata1=%h rv0=%b expected 1 %h 0",
                         i, m1_rvalid, m1_rdata, m0_rvalid, exp_rd1);
            end
            tick();
            idle();
        end
    endtask

    task automatic test_mid_read_reset();
        do_reset();
        set_m0(1'b1, 1'b0, 4'hF, 12'h030, '0);
        set_m1(1'b1, 1'b1, 4'h3, 12'h031, 32'hA5A5_5A5A);
        #1; predict();
        n_checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_accept: got gnt0/gnt1=%b%b expected 10", m0_gnt, m1_gnt);
        end
        tick();
        m0_req = 1'b0;
        rst = 1'b1;
        #1; predict();
        n_checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== '0 || m1_gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_drop: got rv0=%b rdata0=%h gnt1=%b expected 0 0 0",
                     m0_rvalid, m0_rdata, m1_gnt);
        end
        tick();
        rst = 1'b0;
        m0_req = 1'b1;
        #1; predict();
        n_checks++;
        if (conflict_cnt !== 4'd0 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_state: got cnt=%0d gnt0/gnt1=%b%b expected 0 10",
                     conflict_cnt, m0_gnt, m1_gnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_m0(1'b1, 1'b0, 4'hF, 12'($urandom_range(63)), '0);
            set_m1(1'b1, 1'b0, 4'hF, 12'($urandom_range(63)), '0);
            #1; predict();
            n_checks++;
            if (conflict_cnt !== ref_cnt) begin
                n_errors++;
                $display("FAIL sat_cnt cyc%0d: got %0d expected %0d", i, conflict_cnt, ref_cnt);
            end
            tick();
        end
        idle();
        #1; predict();
        n_checks++;
        if (conflict_cnt !== 4'd15) begin
            n_errors++;
            $display("FAIL sat_hold: got %0d expected 15", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_random(input int ncyc);
        logic g0, g1;
        g0 = 1'b0;
        g1 = 1'b0;
        idle();
        rst = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            // A master holds its request until granted, occasionally abandoning it.
            if (!m0_req || g0) begin
                if ($urandom_range(99) < 60)
                    set_m0(1'b1, 1'($urandom_range(1)), 4'($urandom), 12'($urandom_range(31)), $urandom);
                else m0_req = 1'b0;
            end else if ($urandom_range(99) < 10) m0_req = 1'b0;
            if (!m1_req || g1) begin
                if ($urandom_range(99) < 60)
                    set_m1(1'b1, 1'($urandom_range(1)), 4'($urandom), 12'($urandom_range(31)), $urandom);
                else m1_req = 1'b0;
            end else if ($urandom_range(99) < 10) m1_req = 1'b0;
            rst = ($urandom_range(99) < 3);
            #1; predict();
            n_checks++;
            if ({m0_gnt, m1_gnt, mem_en} !== {eg0, eg1, exp_en}) begin
                n_errors++;
                $display("FAIL rand_gnt cyc%0d: got gnt0/gnt1/en=%b%b%b expected %b%b%b",
                         i, m0_gnt, m1_gnt, mem_en, eg0, eg1, exp_en);
            end
            n_checks++;
            if ({mem_we, mem_be, mem_addr, mem_wdata} !== {exp_we, exp_be, exp_addr, exp_wdata}) begin
                n_errors++;
                $display("FAIL rand_mem cyc%0d: got we=%b be=%h addr=%h wdata=%h expected %b %h %h %h",
                         i, mem_we, mem_be, mem_addr, mem_wdata, exp_we, exp_be, exp_addr, exp_wdata);
            end
            n_checks++;
            if ({m0_rvalid, m0_rdata} !== {exp_rv0, exp_rd0}) begin
                n_errors++;
                $display("FAIL rand_rsp0 cyc%0d: got rv=%b rdata=%h expected %b %h",
                         i, m0_rvalid, m0_rdata, exp_rv0, exp_rd0);
            end
            n_checks++;
            if ({m1_rvalid, m1_rdata} !== {exp_rv1, exp_rd1}) begin
                n_errors++;
                $display("FAIL rand_rsp1 cyc%0d: got rv=%b rdata=%h expected %b %h",
                         i, m1_rvalid, m1_rdata, exp_rv1, exp_rd1);
            end
            n_checks++;
            if (conflict_cnt !== ref_cnt) begin
                n_errors++;
                $display("FAIL rand_cnt cyc%0d: got %0d expected %0d", i, conflict_cnt, ref_cnt);
            end
            g0 = eg0;
            g1 = eg1;
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_mid_read_reset();
        test_saturation();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmem_arbiter

`default_nettype wire
